// File: rtl/rc4_msg_ctrl.sv
// Message controller upstream of the RC4 crypt core: key register, show-ahead input FIFO, rc4_ini pulse, end-of-message detection.
// Optional feature macro: RC4_KEY_CLEAR_EN (zero the key register on entry to DONE).
module rc4_msg_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             key_wr,
  input  logic [127:0]     key_wdata,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             rc4_ini,
  output logic [127:0]     key_in,
  output logic [7:0]       data_in,
  input  logic             rc4_data_rd,
  input  logic             rc4_data_wr,
  output logic             busy,
  output logic             msg_done,
  output logic             underflow_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      LVL_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]      LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]    PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic [LEN_W-1:0] in_cnt_r;
  logic [LEN_W-1:0] out_cnt_r;
  logic [LEN_W-1:0] len_r;
  logic [127:0]     key_r;
  logic             underflow_r;
  logic [7:0]       mem_r [FIFO_DEPTH];

  logic start_s;
  logic active_s;
  logic in_ready_s;
  logic push_s;
  logic pop_s;
  logic under_s;
  logic wr_cnt_s;
  logic wr_last_s;
  logic done_entry_s;

  assign start_s      = (state_r == ST_IDLE) && start;
  assign active_s     = (state_r == ST_INIT) || (state_r == ST_RUN);
  assign in_ready_s   = active_s && (level_r < LVL_FULL) && (in_cnt_r < len_r);
  assign push_s       = in_valid && in_ready_s;
  assign pop_s        = active_s && rc4_data_rd && (level_r != LVL_ZERO);
  assign under_s      = active_s && rc4_data_rd && (level_r == LVL_ZERO);
  assign wr_cnt_s     = (state_r == ST_RUN) && rc4_data_wr && (out_cnt_r != len_r);
  assign wr_last_s    = wr_cnt_s && ((out_cnt_r + LEN_ONE) == len_r);
  assign done_entry_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);

  assign in_ready      = in_ready_s;
  assign rc4_ini       = (state_r == ST_INIT);
  assign key_in        = key_r;
  assign data_in       = (level_r != LVL_ZERO) ? mem_r[rd_ptr_r] : 8'h00;
  assign busy          = (state_r != ST_IDLE);
  assign msg_done      = (state_r == ST_DONE);
  assign underflow_err = underflow_r;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a zero-length message skips straight to DONE without rc4_ini.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (msg_len != LEN_ZERO) begin
            state_nxt_s = ST_INIT;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_INIT: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (wr_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO pointers, level, message counters and sticky underflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      level_r     <= LVL_ZERO;
      in_cnt_r    <= LEN_ZERO;
      out_cnt_r   <= LEN_ZERO;
      len_r       <= LEN_ZERO;
      underflow_r <= 1'b0;
    end else if (start_s) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      level_r     <= LVL_ZERO;
      in_cnt_r    <= LEN_ZERO;
      out_cnt_r   <= LEN_ZERO;
      len_r       <= msg_len;
      underflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        in_cnt_r <= in_cnt_r + LEN_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
      if (wr_cnt_s) begin
        out_cnt_r <= out_cnt_r + LEN_ONE;
      end
      if (under_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care while level is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Key register, writable only in IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_r <= 128'h0;
`ifdef RC4_KEY_CLEAR_EN
    end else if (done_entry_s) begin
      key_r <= 128'h0;
`endif
    end else if ((state_r == ST_IDLE) && key_wr) begin
      key_r <= key_wdata;
    end
  end

`ifndef RC4_KEY_CLEAR_EN
  logic unused_s;
  assign unused_s = done_entry_s;
`endif

endmodule

// File: tb/tb_rc4_msg_ctrl.sv
// Directed self-checking bench for rc4_msg_ctrl (FIFO_DEPTH=16, LEN_W=16).
module tb_rc4_msg_ctrl;

  logic         clk;
  logic         rstn;
  logic         key_wr;
  logic [127:0] key_wdata;
  logic         start;
  logic [15:0]  msg_len;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         rc4_ini;
  logic [127:0] key_in;
  logic [7:0]   data_in;
  logic         rc4_data_rd;
  logic         rc4_data_wr;
  logic         busy;
  logic         msg_done;
  logic         underflow_err;

  int checks;
  int failures;

  localparam logic [127:0] K1 = 128'h0102030405060708090a0b0c0d0e0f10;
  localparam logic [127:0] K2 = 128'hdeadbeef_00112233_44556677_8899aabb;
  localparam logic [127:0] K3 = 128'hcafef00d_cafef00d_12345678_9abcdef0;

  rc4_msg_ctrl #(.FIFO_DEPTH(16), .LEN_W(16)) dut (
    .clk(clk), .rstn(rstn), .key_wr(key_wr), .key_wdata(key_wdata),
    .start(start), .msg_len(msg_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rc4_ini(rc4_ini), .key_in(key_in), .data_in(data_in),
    .rc4_data_rd(rc4_data_rd), .rc4_data_wr(rc4_data_wr), .busy(busy),
    .msg_done(msg_done), .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; key_wr = 1'b0; key_wdata = 128'h0; start = 1'b0; msg_len = 16'd0;
    in_valid = 1'b0; in_data = 8'h00; rc4_data_rd = 1'b0; rc4_data_wr = 1'b0;
    #12;
    checks++;
    if ({in_ready, rc4_ini, busy, msg_done, underflow_err} !== 5'b00000) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, rc4_ini, busy, msg_done, underflow_err});
    end
    checks++;
    if (key_in !== 128'h0 || data_in !== 8'h00) begin
      failures++; $display("FAIL reset_data got key=%h data=%h exp=0", key_in, data_in);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    key_wr = 1'b1; key_wdata = K1;
    tick();
    key_wr = 1'b0;
    checks++;
    if (key_in !== K1) begin failures++; $display("FAIL basic_key got=%h exp=%h", key_in, K1); end
    start = 1'b1; msg_len = 16'd5;
    tick();
    start = 1'b0;
    checks++;
    if ({rc4_ini, busy, in_ready} !== 3'b111) begin
      failures++; $display("FAIL basic_ini got=%b exp=111", {rc4_ini, busy, in_ready});
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      tick();
      if (i == 0) begin
        checks++;
        if (rc4_ini !== 1'b0) begin failures++; $display("FAIL basic_ini_pulse got=%b exp=0", rc4_ini); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_len got=%b exp=0", in_ready); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_in !== 8'hA0 + 8'(i)) begin
        failures++; $display("FAIL basic_data%0d got=%h exp=%h", i, data_in, 8'hA0 + 8'(i));
      end
      rc4_data_rd = 1'b1; rc4_data_wr = 1'b1;
      tick();
      checks++;
      if (msg_done !== (i == 4)) begin failures++; $display("FAIL basic_done%0d got=%b exp=%b", i, msg_done, (i == 4)); end
    end
    rc4_data_rd = 1'b0; rc4_data_wr = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
    tick();
    checks++;
    if ({msg_done, busy, underflow_err} !== 3'b000) begin
      failures++; $display("FAIL basic_end got=%b exp=000", {msg_done, busy, underflow_err});
    end
  endtask

  task automatic test_full_fifo();
    int   sent;
    int   rcv;
    logic rdy;
    sent = 0; rcv = 0;
    start = 1'b1; msg_len = 16'd40;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_data = 8'(sent);
      rdy = in_ready;
      tick();
      if (rdy) sent++;
    end
    checks++;
    if (sent !== 16 || in_ready !== 1'b0) begin
      failures++; $display("FAIL full_stall got sent=%0d ready=%b exp sent=16 ready=0", sent, in_ready);
    end
    for (int c = 0; c < 200 && rcv < 40; c++) begin
      in_valid = (sent < 40); in_data = 8'(sent);
      rc4_data_rd = 1'b1; rc4_data_wr = 1'b1;
      checks++;
      if (data_in !== 8'(rcv)) begin failures++; $display("FAIL full_data%0d got=%h exp=%h", rcv, data_in, 8'(rcv)); end
      rdy = in_ready;
      tick();
      if (rdy && in_valid) sent++;
      rcv++;
    end
    rc4_data_rd = 1'b0; rc4_data_wr = 1'b0; in_valid = 1'b0;
    checks++;
    if (sent !== 40 || rcv !== 40) begin failures++; $display("FAIL full_count got sent=%0d rcv=%0d exp=40", sent, rcv); end
    checks++;
    if ({msg_done, underflow_err} !== 2'b10) begin
      failures++; $display("FAIL full_done got=%b exp=10", {msg_done, underflow_err});
    end
    tick();
  endtask

  task automatic test_underflow();
    start = 1'b1; msg_len = 16'd3;
    tick();
    start = 1'b0;
    rc4_data_rd = 1'b1;
    checks++;
    if (data_in !== 8'h00) begin failures++; $display("FAIL under_data got=%h exp=00", data_in); end
    tick();
    rc4_data_rd = 1'b0;
    checks++;
    if ({underflow_err, data_in} !== {1'b1, 8'h00}) begin
      failures++; $display("FAIL under_flag got err=%b data=%h exp err=1 data=00", underflow_err, data_in);
    end
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    checks++;
    if (data_in !== 8'h5A) begin failures++; $display("FAIL under_push got=%h exp=5a", data_in); end
    rc4_data_wr = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rc4_data_wr = 1'b0;
    checks++;
    if (msg_done !== 1'b1) begin failures++; $display("FAIL under_done got=%b exp=1", msg_done); end
    tick();
    checks++;
    if ({underflow_err, busy} !== 2'b10) begin
      failures++; $display("FAIL under_sticky got=%b exp=10", {underflow_err, busy});
    end
  endtask

  task automatic test_zero_len();
    start = 1'b1; msg_len = 16'd0;
    tick();
    start = 1'b0;
    checks++;
    if ({rc4_ini, msg_done, busy, underflow_err, in_ready} !== 5'b01100 || data_in !== 8'h00) begin
      failures++; $display("FAIL zero_done got=%b data=%h exp=01100 data=00",
                           {rc4_ini, msg_done, busy, underflow_err, in_ready}, data_in);
    end
    tick();
    checks++;
    if ({msg_done, busy} !== 2'b00) begin failures++; $display("FAIL zero_idle got=%b exp=00", {msg_done, busy}); end
  endtask

  task automatic test_reset_abort();
    start = 1'b1; msg_len = 16'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    rc4_data_rd = 1'b1; rc4_data_wr = 1'b1;
    tick(); tick();
    rc4_data_rd = 1'b0; rc4_data_wr = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre got=%b exp=1", busy); end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({in_ready, rc4_ini, busy, msg_done, underflow_err} !== 5'b00000 || key_in !== 128'h0 || data_in !== 8'h00) begin
      failures++; $display("FAIL abort_async got=%b key=%h data=%h exp=0",
                           {in_ready, rc4_ini, busy, msg_done, underflow_err}, key_in, data_in);
    end
    tick(); tick();
    checks++;
    if ({msg_done, busy} !== 2'b00) begin failures++; $display("FAIL abort_hold got=%b exp=00", {msg_done, busy}); end
    rstn = 1'b1;
    tick();
    key_wr = 1'b1; key_wdata = K2;
    tick();
    key_wr = 1'b0;
    start = 1'b1; msg_len = 16'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_in !== 8'hC0 + 8'(i)) begin failures++; $display("FAIL abort_data%0d got=%h exp=%h", i, data_in, 8'hC0 + 8'(i)); end
      rc4_data_rd = 1'b1; rc4_data_wr = 1'b1;
      tick();
    end
    rc4_data_rd = 1'b0; rc4_data_wr = 1'b0;
    checks++;
    if ({msg_done, underflow_err} !== 2'b10) begin
      failures++; $display("FAIL abort_rerun got=%b exp=10", {msg_done, underflow_err});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_key;
`ifdef RC4_KEY_CLEAR_EN
    exp_key = 128'h0;
`else
    exp_key = K3;
`endif
    key_wr = 1'b1; key_wdata = K3;
    tick();
    key_wr = 1'b0;
    for (int m = 0; m < 2; m++) begin
      start = 1'b1; msg_len = 16'd1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_data = 8'hE0 + 8'(m);
      tick();
      in_valid = 1'b0;
      checks++;
      if (data_in !== 8'hE0 + 8'(m)) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", m, data_in, 8'hE0 + 8'(m)); end
      rc4_data_rd = 1'b1; rc4_data_wr = 1'b1;
      tick();
      rc4_data_rd = 1'b0; rc4_data_wr = 1'b0;
      checks++;
      if (msg_done !== 1'b1 || key_in !== exp_key) begin
        failures++; $display("FAIL b2b_key%0d got done=%b key=%h exp done=1 key=%h", m, msg_done, key_in, exp_key);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_full_fifo();
    test_underflow();
    test_zero_len();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
